// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants for the writeback slice.
// Load decode helper used by the writeback stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam logic [4:0] REG_RA   = 5'd31;

  function automatic logic is_load(
    input logic [5:0] op
  );
    return op inside {OP_LB, OP_LH, OP_LW,
                      OP_LBU, OP_LHU};
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bus plus decode read ports.
// master = pipeline/decode side, slave = wb_regfile.
interface wb_regfile_if;

  logic [31:0] ins_w;
  logic [31:0] pc_w;
  logic [31:0] alu_result;
  logic [31:0] dm_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;
  logic        align_err;

  modport master (
    output ins_w, pc_w, alu_result, dm_data,
    output rs_addr, rt_addr,
    input  rs_data, rt_data,
    input  wb_en, wb_addr, wb_data,
    input  retire_cnt, align_err
  );

  modport slave (
    input  ins_w, pc_w, alu_result, dm_data,
    input  rs_addr, rt_addr,
    output rs_data, rt_data,
    output wb_en, wb_addr, wb_data,
    output retire_cnt, align_err
  );

endinterface

// File: rtl/wb_load_ext.sv
// Load data lane select (big-endian) and sign/zero extension.
// Flags halfword/word loads whose address is misaligned.
module wb_load_ext
  import mips_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_misal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_data[7:0];
    unique case (i_addr)
      2'd0: w_byte = i_data[31:24];
      2'd1: w_byte = i_data[23:16];
      2'd2: w_byte = i_data[15:8];
      2'd3: w_byte = i_data[7:0];
      default: ;
    endcase
  end

  assign w_half = i_addr[1] ? i_data[15:0]
                            : i_data[31:16];

  always_comb begin
    o_data  = i_data;
    o_misal = 1'b0;
    unique case (1'b1)
      (i_op == OP_LB):
        o_data = {{24{w_byte[7]}}, w_byte};
      (i_op == OP_LBU):
        o_data = {24'h0, w_byte};
      (i_op == OP_LH): begin
        o_data  = {{16{w_half[15]}}, w_half};
        o_misal = i_addr[0];
      end
      (i_op == OP_LHU): begin
        o_data  = {16'h0, w_half};
        o_misal = i_addr[0];
      end
      (i_op == OP_LW):
        o_misal = |i_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + 32x32 register file, retire counter, align flag.
// Define WB_BYPASS_EN to forward wb_data to same-cycle reads.
module wb_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);

  logic [31:0] r_regs [32];
  logic [31:0] r_cnt;
  logic        r_err;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_pc8;
  logic [31:0] w_ext;
  logic        w_misal;
  logic        w_we;
  logic [4:0]  w_dst;
  logic [31:0] w_val;
  logic        w_wen;
  logic        w_unused;

  assign w_op  = bus.ins_w[31:26];
  assign w_rt  = bus.ins_w[20:16];
  assign w_rd  = bus.ins_w[15:11];
  assign w_fn  = bus.ins_w[5:0];
  assign w_pc8 = bus.pc_w + 32'd8;
  assign w_unused = ^{bus.ins_w[25:21],
                      bus.ins_w[10:6]};

  wb_load_ext u_ext (
    .i_op    (w_op),
    .i_addr  (bus.alu_result[1:0]),
    .i_data  (bus.dm_data),
    .o_data  (w_ext),
    .o_misal (w_misal)
  );

  always_comb begin
    w_we  = 1'b0;
    w_dst = w_rt;
    w_val = bus.alu_result;
    unique case (1'b1)
      (w_op == OP_RTYPE): begin
        w_we  = (w_fn != FN_JR);
        w_dst = w_rd;
        if (w_fn == FN_JALR) w_val = w_pc8;
      end
      (w_op == OP_JAL): begin
        w_we  = 1'b1;
        w_dst = REG_RA;
        w_val = w_pc8;
      end
      (w_op inside {OP_ADDI, OP_ADDIU,
                    OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI,
                    OP_XORI, OP_LUI}):
        w_we = 1'b1;
      is_load(w_op): begin
        w_we  = 1'b1;
        w_val = w_ext;
      end
      default: ;
    endcase
  end

  assign w_wen = w_we & (w_dst != 5'd0) & ~w_misal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (bus.ins_w != '0) r_cnt <= r_cnt + 32'd1;
      if (w_misal) r_err <= 1'b1;
      if (w_wen) r_regs[w_dst] <= w_val;
    end
  end

  logic [31:0] w_rs_arr;
  logic [31:0] w_rt_arr;

  assign w_rs_arr = (bus.rs_addr == 5'd0) ? '0
                  : r_regs[bus.rs_addr];
  assign w_rt_arr = (bus.rt_addr == 5'd0) ? '0
                  : r_regs[bus.rt_addr];

`ifdef WB_BYPASS_EN
  // w_wen implies w_dst != 0, so $0 is never forwarded
  assign bus.rs_data =
    (w_wen && bus.rs_addr == w_dst) ? w_val : w_rs_arr;
  assign bus.rt_data =
    (w_wen && bus.rt_addr == w_dst) ? w_val : w_rt_arr;
`else
  assign bus.rs_data = w_rs_arr;
  assign bus.rt_data = w_rt_arr;
`endif

  assign bus.wb_en      = w_wen;
  assign bus.wb_addr    = w_dst;
  assign bus.wb_data    = w_val;
  assign bus.retire_cnt = r_cnt;
  assign bus.align_err  = r_err;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an ISA-level model.
// Directed literal checks pin the model's lane and extension rules.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err = 0;

  bit [31:0] m_regs [32];
  bit [31:0] m_cnt = 0;
  bit        m_err = 0;
  bit        m_live = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void ref_wb(
    input  logic [31:0] ins, pc, alu, dm,
    output logic        en,
    output logic [4:0]  a,
    output logic [31:0] d,
    output logic        mis
  );
    logic w;
    int sh;
    logic [7:0] b;
    logic [15:0] h;
    logic [5:0] op;
    op = ins[31:26];
    w = 0; a = ins[20:16]; d = alu; mis = 0;
    case (op)
      6'h00: begin
        a = ins[15:11];
        w = (ins[5:0] != 6'h08);
        if (ins[5:0] == 6'h09) d = pc + 32'd8;
      end
      6'h03: begin a = 5'd31; w = 1; d = pc + 32'd8; end
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: w = 1;
      6'h20, 6'h24: begin
        sh = 8 * (3 - int'(alu[1:0]));
        b = 8'(dm >> sh);
        d = (op == 6'h20) ? 32'($signed(b))
                          : 32'(b);
        w = 1;
      end
      6'h21, 6'h25: begin
        h = alu[1] ? dm[15:0] : dm[31:16];
        d = (op == 6'h21) ? 32'($signed(h))
                          : 32'(h);
        w = 1;
        mis = alu[0];
      end
      6'h23: begin
        d = dm; w = 1;
        mis = (alu % 4) != 0;
      end
      default: ;
    endcase
    en = w && (a != 0) && !mis;
  endfunction

  always @(posedge clk) begin
    logic en, mis;
    logic [4:0] a;
    logic [31:0] d;
    if (!reset) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_cnt = 0; m_err = 0; m_live = 1;
    end else if (m_live) begin
      ref_wb(bus.ins_w, bus.pc_w, bus.alu_result,
             bus.dm_data, en, a, d, mis);
      if (bus.ins_w != 0) m_cnt = m_cnt + 1;
      if (mis) m_err = 1;
      if (en) m_regs[a] = d;
    end
  end

  function automatic logic [31:0] ref_rd(
    input logic [4:0] ra, input logic en,
    input logic [4:0] a, input logic [31:0] d
  );
`ifdef WB_BYPASS_EN
    if (en && ra == a) return d;
`endif
    return (ra == 0) ? 32'h0 : m_regs[ra];
  endfunction

  always @(negedge clk) begin
    logic en, mis;
    logic [4:0] a;
    logic [31:0] d;
    if (m_live) begin
      ref_wb(bus.ins_w, bus.pc_w, bus.alu_result,
             bus.dm_data, en, a, d, mis);
      chk("wb_en", 32'(bus.wb_en), 32'(en));
      if (en) begin
        chk("wb_addr", 32'(bus.wb_addr), 32'(a));
        chk("wb_data", bus.wb_data, d);
      end
      chk("rs_data", bus.rs_data,
          ref_rd(bus.rs_addr, en, a, d));
      chk("rt_data", bus.rt_data,
          ref_rd(bus.rt_addr, en, a, d));
      chk("retire_cnt", bus.retire_cnt, m_cnt);
      chk("align_err", 32'(bus.align_err), 32'(m_err));
    end
  end

  function automatic logic [31:0] rtype(
    input logic [4:0] rd, input logic [5:0] fn
  );
    return {6'h00, 10'h0, rd, 5'h0, fn};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] rt
  );
    return {op, 5'h0, rt, 16'h0};
  endfunction

  task automatic step(input logic [31:0] ins, pc,
                      input logic [31:0] alu, dm,
                      input logic [4:0] rs, rt);
    @(posedge clk);
    #1;
    bus.ins_w = ins;
    bus.pc_w = pc;
    bus.alu_result = alu;
    bus.dm_data = dm;
    bus.rs_addr = rs;
    bus.rt_addr = rt;
  endtask

  bit [5:0] ops [15] = '{6'h00, 6'h00, 6'h03, 6'h08,
                         6'h0D, 6'h0F, 6'h20, 6'h21,
                         6'h23, 6'h24, 6'h25, 6'h2B,
                         6'h04, 6'h02, 6'h09};
  bit [5:0] fns [4] = '{6'h20, 6'h08, 6'h09, 6'h21};

  initial begin
    logic [31:0] ins;
    bus.ins_w = 0; bus.pc_w = 0;
    bus.alu_result = 0; bus.dm_data = 0;
    bus.rs_addr = 5; bus.rt_addr = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt", bus.retire_cnt, 32'h0);
    chk("rst_err", 32'(bus.align_err), 32'h0);
    chk("rst_rs", bus.rs_data, 32'h0);

    @(posedge clk); #1 reset = 1;
    step(rtype(5'd5, 6'h20), 0, 32'h1234, 0, 5, 0);
    @(negedge clk);
    chk("add_en", 32'(bus.wb_en), 32'h1);
    chk("add_addr", 32'(bus.wb_addr), 32'd5);
    step(0, 0, 0, 0, 5, 0);
    @(negedge clk);
    chk("add_rd", bus.rs_data, 32'h0000_1234);
    chk("add_cnt", bus.retire_cnt, 32'd1);

    step(itype(6'h20, 7), 0, 32'h101, 32'h11F0_2233, 0, 0);
    @(negedge clk);
    chk("lb_data", bus.wb_data, 32'hFFFF_FFF0);
    step(itype(6'h24, 8), 0, 32'h101, 32'h11F0_2233, 0, 0);
    @(negedge clk);
    chk("lbu_data", bus.wb_data, 32'h0000_00F0);
    step(itype(6'h21, 10), 0, 32'h102, 32'hAAAA_8001, 7, 8);
    @(negedge clk);
    chk("lb_rd", bus.rs_data, 32'hFFFF_FFF0);
    chk("lbu_rd", bus.rt_data, 32'h0000_00F0);
    chk("lh_data", bus.wb_data, 32'hFFFF_8001);
    step(itype(6'h23, 11), 0, 32'h102, 32'hAAAA_8001, 10, 0);
    @(negedge clk);
    chk("lh_rd", bus.rs_data, 32'hFFFF_8001);
    chk("lw_mis_en", 32'(bus.wb_en), 32'h0);
    step(itype(6'h03, 0), 32'h0040_0010, 0, 0, 11, 0);
    @(negedge clk);
    chk("lw_err", 32'(bus.align_err), 32'h1);
    chk("lw_cnt", bus.retire_cnt, 32'd5);
    chk("lw_nowr", bus.rs_data, 32'h0);
    chk("jal_addr", 32'(bus.wb_addr), 32'd31);
    chk("jal_data", bus.wb_data, 32'h0040_0018);
    step(rtype(5'd0, 6'h20), 0, 32'h55, 0, 31, 0);
    @(negedge clk);
    chk("r0_en", 32'(bus.wb_en), 32'h0);
    step(itype(6'h0D, 9), 0, 32'hBEEF, 0, 31, 9);
    @(negedge clk);
    chk("jal_rd", bus.rs_data, 32'h0040_0018);
`ifdef WB_BYPASS_EN
    chk("ori_byp", bus.rt_data, 32'h0000_BEEF);
`else
    chk("ori_old", bus.rt_data, 32'h0);
`endif
    step(0, 0, 0, 0, 0, 9);
    @(negedge clk);
    chk("ori_rd", bus.rt_data, 32'h0000_BEEF);
    chk("r0_rd", bus.rs_data, 32'h0);
    chk("err_sticky", 32'(bus.align_err), 32'h1);

    for (int k = 0; k < 2000; k++) begin
      int s;
      s = $urandom_range(0, 15);
      if (s == 15) ins = 0;
      else begin
        ins = {ops[s], 26'($urandom)};
        if (ops[s] == 6'h00)
          ins[5:0] = fns[$urandom_range(0, 3)];
      end
      step(ins, $urandom, $urandom, $urandom,
           5'($urandom), 5'($urandom));
      reset = ($urandom_range(0, 63) != 0);
    end
    reset = 1;
    step(itype(6'h23, 12), 0, 32'h100, 32'hCAFE_F00D, 0, 0);
    step(itype(6'h21, 13), 0, 32'h101, 0, 0, 0);
    step(itype(6'h23, 12), 0, 32'h100, 32'hCAFE_F00D, 12, 0);
    reset = 0;
    step(0, 0, 0, 0, 12, 13);
    @(negedge clk);
    chk("mid_rst_rs", bus.rs_data, 32'h0);
    chk("mid_rst_cnt", bus.retire_cnt, 32'h0);
    chk("mid_rst_err", 32'(bus.align_err), 32'h0);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 5'(i), 5'(31 - i));
      @(negedge clk);
      chk("rst_all", bus.rs_data | bus.rt_data, 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
